system_host_ctrl: RTL

//  Host-side master for the scheduler core system interface (the tb end of system_if).

---
 rtl/system_host_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/system_host_ctrl.sv
// Host-side master for the scheduler core system interface: streams a program
// image into memory, runs the core until halt (or timeout), then dumps a memory window.
module system_host_ctrl #(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] load_base,
    input  logic [15:0] load_count,
    input  logic [31:0] dump_base,
    input  logic [15:0] dump_count,
    input  logic        prog_valid,
    input  logic [31:0] prog_data,
    output logic        prog_ready,
    output logic        dump_valid,
    output logic [31:0] dump_data,
    input  logic        dump_ready,
    output logic        tbCTRL,
    output logic        WEN,
    output logic        REN,
    output logic [31:0] addr,
    output logic [31:0] store,
    input  logic [31:0] load,
    input  logic        halt,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [31:0] run_cycles
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DREQ  = 3'd3;
    localparam logic [2:0] DWAIT = 3'd4;
    localparam logic [2:0] DOUT  = 3'd5;
    localparam logic [2:0] FIN   = 3'd6;

    localparam logic [32:0]      RUN_LIMIT = (33'd1 << TIMEOUT_W) - 33'd1;
    localparam int unsigned      LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);

    logic [2:0]       state;
    logic [31:0]      loadBase;
    logic [31:0]      dumpBase;
    logic [15:0]      loadCount;
    logic [15:0]      dumpCount;
    logic [15:0]      idx;
    logic [LAT_W-1:0] latCnt;
    logic [31:0]      dumpData;
    logic [31:0]      runCycles;
    logic             timeoutErr;

    logic [31:0]      loadAddr;
    logic [31:0]      dumpAddr;
    logic [32:0]      runNext;
    logic [16:0]      idxNext;

    always_comb begin
        loadAddr = loadBase + {14'd0, idx, 2'b00};
        dumpAddr = dumpBase + {14'd0, idx, 2'b00};
        runNext  = {1'b0, runCycles} + 33'd1;
        idxNext  = {1'b0, idx} + 17'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            loadBase   <= '0;
            dumpBase   <= '0;
            loadCount  <= '0;
            dumpCount  <= '0;
            idx        <= '0;
            latCnt     <= '0;
            dumpData   <= '0;
            runCycles  <= '0;
            timeoutErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        loadBase   <= load_base;
                        dumpBase   <= dump_base;
                        loadCount  <= load_count;
                        dumpCount  <= dump_count;
                        idx        <= '0;
                        runCycles  <= '0;
                        timeoutErr <= 1'b0;
                        state      <= (load_count == 16'd0) ? RUN : LOAD;
                    end
                end
                LOAD: begin
                    if (prog_valid) begin
                        if (idxNext == {1'b0, loadCount}) begin
                            idx   <= '0;
                            state <= RUN;
                        end else begin
                            idx <= idxNext[15:0];
                        end
                    end
                end
                RUN: begin
                    if (runCycles != '1) begin
                        runCycles <= runNext[31:0];
                    end
                    // halt wins over a timeout landing on the same cycle
                    if (halt || (runNext == RUN_LIMIT)) begin
                        if (!halt) begin
                            timeoutErr <= 1'b1;
                        end
                        state <= (dumpCount == 16'd0) ? FIN : DREQ;
                    end
                end
                DREQ: begin
                    latCnt <= '0;
                    state  <= DWAIT;
                end
                DWAIT: begin
                    if (latCnt == LAT_LAST) begin
                        dumpData <= load;
                        state    <= DOUT;
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end
                DOUT: begin
                    if (dump_ready) begin
                        idx   <= idxNext[15:0];
                        state <= (idxNext < {1'b0, dumpCount}) ? DREQ : FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tbCTRL     = (state != RUN);
        prog_ready = (state == LOAD);
        WEN        = (state == LOAD) && prog_valid;
        REN        = (state == DREQ);
        store      = (state == LOAD) ? prog_data : '0;
        dump_valid = (state == DOUT);
        busy       = (state != IDLE);
        done       = (state == FIN);
        case (state)
            LOAD:        addr = loadAddr;
            DREQ, DWAIT: addr = dumpAddr;
            default:     addr = '0;
        endcase
    end

    assign dump_data   = dumpData;
    assign timeout_err = timeoutErr;
    assign run_cycles  = runCycles;

endmodule
